generador_rango: RTL
====================

Name: generador_rango

Overview:
- Sequential range sequencer. It latches a signed 5-bit window [limiteInferior, limiteSuperior] and an unsigned step on `inicio`.
- It then emits every value lower, lower+paso, … that is ≤ upper, one per valid/ready handshake.
- It is the producer side of the team's range-check datapath: its `numero` output feeds the range checker's `numero` input, and its latched limits feed the checker's limit inputs.
- Each emitted value is also presented in sign/magnitude form (the inverse view of the checker's two's-complement-to-magnitude step).

Parameters:
- ANCHO, 5, data width in bits; two's complement, range −2^(ANCHO−1)..2^(ANCHO−1)−1
- ANCHO_PASO, 3, width of the unsigned step input

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- inicio  in  1  start request; sampled only in REPOSO
- limiteInferior  in  ANCHO  signed lower bound, inclusive
- limiteSuperior  in  ANCHO  signed upper bound, inclusive
- paso  in  ANCHO_PASO  unsigned step; value 0 is treated as 1
- listo  in  1  consumer ready
- numero  out  ANCHO  current value, two's complement
- signo  out  1  numero[ANCHO−1]
- magnitud  out  ANCHO  |numero|, unsigned; −16 → 16 (5'b10000)
- valido  out  1  numero/signo/magnitud are valid
- ocupado  out  1  high from the cycle after accepted inicio until the cycle fin asserts
- fin  out  1  one-cycle pulse at end of sequence
- error  out  1  one-cycle pulse when latched lower > upper (signed); no values emitted
- cuenta  out  ANCHO+1  number of handshakes completed in the current or last sequence

Behaviour:
- Reset (synchronous, active-high):
  - State = REPOSO.
  - numero=0, signo=0, magnitud=0, valido=0, ocupado=0, fin=0, error=0, cuenta=0.
  - rst dominates every other input in the same cycle.
  - Reset mid-sequence abandons the sequence: no fin pulse, valido drops the next cycle.
- States: REPOSO, EMITIR, TERMINA.
- REPOSO:
  - inicio=1 latches both limits and paso (0→1), clears cuenta.
  - Compares the limits as signed values.
  - If lower > upper: pulse error for one cycle, stay in REPOSO.
  - Otherwise: numero←lower, valido←1, ocupado←1, go to EMITIR. First value is visible the cycle after inicio (1-cycle latency).
- EMITIR:
  - valido=1 held. numero/signo/magnitud remain stable while listo=0 (AXI-style hold).
  - A handshake is valido&listo in the same cycle. On handshake, cuenta increments.
  - Next value is computed in ANCHO+1-bit signed arithmetic (sign-extended numero + zero-extended paso), so there is no wrap-around at +15.
  - If the next value ≤ latched upper: numero←next, valido stays 1 (back-to-back, one value per cycle when listo is held high).
  - Else: valido←0, go to TERMINA.
- TERMINA:
  - fin=1 for exactly one cycle, ocupado←0, go to REPOSO.
  - cuenta holds its final value until the next accepted inicio.
- inicio while not in REPOSO is ignored. Limit/step inputs changing mid-sequence have no effect (latched copies only).
- lower == upper emits exactly one value.
- Full range −16..15 with paso=1 emits 32 values, so cuenta=32 (requires ANCHO+1 bits).
- signo/magnitud are combinational from the numero register, so there is no added latency.

Decomposition:
- Shared package `rango_pkg`:
  - state enum {REPOSO, EMITIR, TERMINA}
  - ANCHO/ANCHO_PASO defaults
  - signed compare and two's-complement magnitude function, reused by the range checker rewrite
- One natural sub-module: `c2_a_magnitud` (combinational two's complement → sign + magnitude, ANCHO-parameterised). It is shared with the checker. The FSM, step adder and counter stay in `generador_rango`.

Test Plan:
- lower=−3 (5'b11101), upper=2, paso=0, listo=1 constant → numero −3,−2,−1,0,1,2 on 6 consecutive cycles starting 1 cycle after inicio; fin pulses the cycle after 2 is accepted; cuenta=6.
- lower=10, upper=15, paso=4, listo toggled 1/0 every cycle → emits 10,14 only; each value held stable while listo=0; no 18/−14 wrap; cuenta=2.
- lower=−16, upper=15, paso=1, listo=1 → 32 values; first has signo=1, magnitud=16; last is 15; cuenta=32; fin once.
- lower=5, upper=−5 → error pulse 1 cycle, valido never 1, ocupado stays 0, cuenta=0.
- lower=upper=−7 → single value numero=5'b11001, signo=1, magnitud=7; then fin.
- Start lower=0, upper=15; assert rst after 3 handshakes → next cycle all outputs at reset values, no fin; inicio asserted during EMITIR before the reset has no effect.

Source files
------------

// File: rtl/rango_pkg.sv
// Shared definitions for the range-check datapath: sequencer states,
// default widths, and signed helpers used by producer and checker.
package rango_pkg;

    localparam int unsigned ANCHO_DEF      = 5;
    localparam int unsigned ANCHO_PASO_DEF = 3;
    // Internal width of the helper functions; callers sign-extend into it.
    localparam int unsigned ANCHO_MAX      = 16;

    typedef enum logic [1:0] {
        REPOSO,
        EMITIR,
        TERMINA
    } estado_t;

    // Signed a <= b on sign-extended operands.
    function automatic logic menor_igual_c2(
        input logic signed [ANCHO_MAX-1:0] a,
        input logic signed [ANCHO_MAX-1:0] b
    );
        return (a <= b);
    endfunction

    // Two's complement to magnitude; the most negative value of the caller's
    // width maps to 2^(ANCHO-1), which still fits after truncation.
    function automatic logic [ANCHO_MAX-1:0] magnitud_c2(
        input logic signed [ANCHO_MAX-1:0] v
    );
        logic [ANCHO_MAX-1:0] u;
        u = v;
        if (v[ANCHO_MAX-1]) begin
            return ~u + ANCHO_MAX'(1);
        end
        return u;
    endfunction

endpackage

// File: rtl/c2_a_magnitud.sv
// Combinational two's complement -> sign + magnitude view.
module c2_a_magnitud
    import rango_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
) (
    input  logic [ANCHO-1:0] valor,
    output logic             signo,
    output logic [ANCHO-1:0] magnitud
);

    // Sign is the MSB; magnitude goes through the shared helper.
    always_comb begin
        signo    = valor[ANCHO-1];
        magnitud = ANCHO'(magnitud_c2(ANCHO_MAX'(signed'(valor))));
    end

endmodule

// File: rtl/generador_rango.sv
// Range sequencer: latches a signed window and a step on inicio and emits
// lower, lower+paso, ... <= upper over a valid/ready handshake.
module generador_rango
    import rango_pkg::*;
#(
    parameter int unsigned ANCHO      = ANCHO_DEF,
    parameter int unsigned ANCHO_PASO = ANCHO_PASO_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inicio,
    input  logic [ANCHO-1:0]      limiteInferior,
    input  logic [ANCHO-1:0]      limiteSuperior,
    input  logic [ANCHO_PASO-1:0] paso,
    input  logic                  listo,
    output logic [ANCHO-1:0]      numero,
    output logic                  signo,
    output logic [ANCHO-1:0]      magnitud,
    output logic                  valido,
    output logic                  ocupado,
    output logic                  fin,
    output logic                  error,
    output logic [ANCHO:0]        cuenta
);

    estado_t estado_q, estado_d;

    logic signed [ANCHO-1:0] lim_sup_q, lim_sup_d;
    logic [ANCHO_PASO-1:0]   paso_q, paso_d;
    logic [ANCHO-1:0]        numero_q, numero_d;
    logic                    valido_q, valido_d;
    logic                    ocupado_q, ocupado_d;
    logic                    fin_q, fin_d;
    logic                    error_q, error_d;
    logic [ANCHO:0]          cuenta_q, cuenta_d;

    logic                    handshake;
    logic                    rango_ok;
    logic signed [ANCHO:0]   siguiente;
    logic                    siguiente_cabe;

    // Handshake, window check on the raw inputs, and the next candidate
    // computed one bit wider so +15 plus a step never wraps negative.
    always_comb begin
        handshake      = valido_q & listo;
        rango_ok       = menor_igual_c2(ANCHO_MAX'(signed'(limiteInferior)),
                                        ANCHO_MAX'(signed'(limiteSuperior)));
        siguiente      = (ANCHO+1)'(signed'(numero_q)) + (ANCHO+1)'(paso_q);
        siguiente_cabe = menor_igual_c2(ANCHO_MAX'(siguiente),
                                        ANCHO_MAX'(lim_sup_q));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= REPOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            REPOSO: begin
                if (inicio && rango_ok) begin
                    estado_d = EMITIR;
                end
            end
            EMITIR: begin
                if (handshake && !siguiente_cabe) begin
                    estado_d = TERMINA;
                end
            end
            TERMINA: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    // Datapath and registered outputs; fin/error default low so they pulse.
    always_comb begin
        lim_sup_d = lim_sup_q;
        paso_d    = paso_q;
        numero_d  = numero_q;
        valido_d  = valido_q;
        ocupado_d = ocupado_q;
        fin_d     = 1'b0;
        error_d   = 1'b0;
        cuenta_d  = cuenta_q;
        unique case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    lim_sup_d = signed'(limiteSuperior);
                    paso_d    = (paso == '0) ? ANCHO_PASO'(1) : paso;
                    cuenta_d  = '0;
                    if (rango_ok) begin
                        // The lower bound lives on as the first numero.
                        numero_d  = limiteInferior;
                        valido_d  = 1'b1;
                        ocupado_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            EMITIR: begin
                if (handshake) begin
                    cuenta_d = cuenta_q + (ANCHO+1)'(1);
                    if (siguiente_cabe) begin
                        numero_d = siguiente[ANCHO-1:0];
                    end else begin
                        valido_d  = 1'b0;
                        ocupado_d = 1'b0;
                        fin_d     = 1'b1;
                    end
                end
            end
            TERMINA: begin
                ocupado_d = 1'b0;
            end
            default: begin
                valido_d  = 1'b0;
                ocupado_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lim_sup_q <= '0;
            paso_q    <= '0;
            numero_q  <= '0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
            error_q   <= 1'b0;
            cuenta_q  <= '0;
        end else begin
            lim_sup_q <= lim_sup_d;
            paso_q    <= paso_d;
            numero_q  <= numero_d;
            valido_q  <= valido_d;
            ocupado_q <= ocupado_d;
            fin_q     <= fin_d;
            error_q   <= error_d;
            cuenta_q  <= cuenta_d;
        end
    end

    c2_a_magnitud #(
        .ANCHO(ANCHO)
    ) u_c2_a_magnitud (
        .valor   (numero_q),
        .signo   (signo),
        .magnitud(magnitud)
    );

    // Output assignments.
    always_comb begin
        numero  = numero_q;
        valido  = valido_q;
        ocupado = ocupado_q;
        fin     = fin_q;
        error   = error_q;
        cuenta  = cuenta_q;
    end

endmodule
